// File: rtl/brick_pkg.sv
// rtl/brick_pkg.sv - shared screen geometry, colours and paddle FSM states
package brick_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;
    localparam int COORD_W  = 10;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COLOUR_RED   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } paddle_state_t;

endpackage

// File: rtl/paddle_renderer_if.sv
// rtl/paddle_renderer_if.sv - movement/redraw handshake and pixel write port
interface paddle_renderer_if
    import brick_pkg::*;
#(
    parameter int XW = COORD_W
);
    logic                enable;
    logic                left;
    logic                right;
    logic                draw_req;
    logic [XW-1:0]       x_out;
    logic [XW-1:0]       y_out;
    logic [COLOUR_W-1:0] colour;
    logic                wren;
    logic                busy;
    logic                done;
    logic [XW-1:0]       pos_x;

    modport slave (
        input  enable, left, right, draw_req,
        output x_out, y_out, colour, wren, busy, done, pos_x
    );

    modport master (
        output enable, left, right, draw_req,
        input  x_out, y_out, colour, wren, busy, done, pos_x
    );
endinterface

// File: rtl/paddle_scan.sv
// rtl/paddle_scan.sv - raster counter pair walking a W x H rectangle
module paddle_scan #(
    parameter int XW = 10,
    parameter int W  = 16,
    parameter int H  = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          step,
    output logic [XW-1:0] qx,
    output logic [XW-1:0] qy,
    output logic          last
);
    localparam logic [XW-1:0] QX_MAX = XW'(W - 1);
    localparam logic [XW-1:0] QY_MAX = XW'(H - 1);

    // qx runs fastest; clear wins over step so a state change restarts the scan
    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            qx <= '0;
            qy <= '0;
        end else if (step) begin
            if (qx == QX_MAX) begin
                qx <= '0;
                qy <= (qy == QY_MAX) ? '0 : qy + 1'b1;
            end else begin
                qx <= qx + 1'b1;
            end
        end
    end

    // flags the final pixel of the rectangle
    always_comb begin
        last = (qx == QX_MAX) && (qy == QY_MAX);
    end
endmodule

// File: rtl/paddle_renderer.sv
// rtl/paddle_renderer.sv - paddle position register with erase-then-draw pixel streamer
module paddle_renderer #(
    parameter int         XW        = 10,
    parameter int         SCREEN_W  = 160,
    parameter int         PLAT_W    = 16,
    parameter int         PLAT_H    = 2,
    parameter int         PLAT_Y    = 110,
    parameter int         SPEED     = 1,
    parameter logic [2:0] FG_COLOUR = 3'b100,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic             clk,
    input  logic             resetn,
    paddle_renderer_if.slave bus
);
    import brick_pkg::*;

    localparam logic [XW-1:0] MAX_X     = XW'(SCREEN_W - PLAT_W);
    localparam logic [XW:0]   MAX_X_W   = (XW+1)'(SCREEN_W - PLAT_W);
    localparam logic [XW-1:0] POS_RESET = XW'((SCREEN_W - PLAT_W) / 2);
    localparam logic [XW:0]   SPD       = (XW+1)'(SPEED);
    localparam logic [XW-1:0] TOP_Y     = XW'(PLAT_Y);

    generate
        if (PLAT_W > SCREEN_W) begin : g_bad_width
            $error("paddle wider than screen");
        end
        if (PLAT_Y + PLAT_H > SCREEN_H) begin : g_bad_height
            $error("paddle extends below screen");
        end
        if (SCREEN_W >= (1 << XW)) begin : g_bad_coord
            $error("coordinate width too small for screen");
        end
    endgenerate

    paddle_state_t state, state_next;
    logic [XW-1:0] pos_q, pos_next;
    logic [XW-1:0] new_x, old_x, drawn_x;
    logic          drawn_valid;
    logic          accept;
    logic          scan_clear, scan_step, scan_last;
    logic [XW-1:0] qx, qy;
    logic [XW:0]   pos_dec, pos_inc;

    paddle_scan #(.XW(XW), .W(PLAT_W), .H(PLAT_H)) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (scan_clear),
        .step   (scan_step),
        .qx     (qx),
        .qy     (qy),
        .last   (scan_last)
    );

    // clamped move; only honoured in IDLE so a redraw sees one position
    always_comb begin
        pos_dec  = {1'b0, pos_q} - SPD;
        pos_inc  = {1'b0, pos_q} + SPD;
        pos_next = pos_q;
        if (state == S_IDLE && bus.enable && !bus.draw_req) begin
            if (bus.left && !bus.right) begin
                pos_next = pos_dec[XW] ? '0 : pos_dec[XW-1:0];
            end else if (bus.right && !bus.left) begin
                pos_next = (pos_inc > MAX_X_W) ? MAX_X : pos_inc[XW-1:0];
            end
        end
    end

    // next-state logic; the scan counters restart on every state change
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.draw_req) begin
                    accept     = 1'b1;
                    state_next = (drawn_valid && drawn_x != pos_q) ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE: if (scan_last) state_next = S_DRAW;
            S_DRAW:  if (scan_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        scan_clear = (state_next != state);
        scan_step  = (state == S_ERASE) || (state == S_DRAW);
    end

    // state, position and the record of what is currently on screen
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pos_q       <= POS_RESET;
            new_x       <= '0;
            old_x       <= '0;
            drawn_x     <= '0;
            drawn_valid <= 1'b0;
        end else begin
            state <= state_next;
            pos_q <= pos_next;
            if (accept) begin
                new_x <= pos_q;
                old_x <= drawn_x;
            end
            if (state == S_DONE) begin
                drawn_x     <= new_x;
                drawn_valid <= 1'b1;
            end
        end
    end

    // pixel port muxing: erase at the old spot, draw at the new one
    always_comb begin
        bus.wren   = 1'b0;
        bus.x_out  = '0;
        bus.y_out  = '0;
        bus.colour = BG_COLOUR;
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        bus.pos_x  = pos_q;
        case (state)
            S_ERASE: begin
                bus.wren   = 1'b1;
                bus.x_out  = old_x + qx;
                bus.y_out  = TOP_Y + qy;
                bus.colour = BG_COLOUR;
            end
            S_DRAW: begin
                bus.wren   = 1'b1;
                bus.x_out  = new_x + qx;
                bus.y_out  = TOP_Y + qy;
                bus.colour = FG_COLOUR;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_paddle_renderer.sv
// tb/tb_paddle_renderer.sv - self-checking bench for paddle_renderer
module tb_paddle_renderer;
    localparam int PW = 16;
    localparam int PH = 2;
    localparam int N  = PW * PH;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    paddle_renderer_if #(.XW(10)) bus ();
    paddle_renderer_if #(.XW(10)) bus2 ();

    paddle_renderer #(.XW(10), .SCREEN_W(160), .PLAT_W(PW), .PLAT_H(PH), .PLAT_Y(110),
                      .SPEED(1), .FG_COLOUR(3'b100), .BG_COLOUR(3'b000)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    paddle_renderer #(.XW(10), .SCREEN_W(160), .PLAT_W(PW), .PLAT_H(PH), .PLAT_Y(110),
                      .SPEED(4), .FG_COLOUR(3'b100), .BG_COLOUR(3'b000)) u_dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    typedef struct {
        bit l;
        bit r;
        int n;
        int exp_pos;
    } mv_t;

    px_t sbq[$];
    int  checks     = 0;
    int  failures   = 0;
    int  done_total = 0;
    mv_t mv[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_scan(input int base, input int c);
        for (int qy = 0; qy < PH; qy++)
            for (int qx = 0; qx < PW; qx++)
                sbq.push_back('{x: base + qx, y: 110 + qy, c: c});
    endtask

    // scoreboard: every written pixel must match the head of the expected queue
    always @(negedge clk) begin
        px_t p;
        if (bus.done) done_total++;
        if (bus.wren) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pixel x=%0d y=%0d colour=%0d", bus.x_out, bus.y_out, bus.colour);
            end else begin
                p = sbq.pop_front();
                if (int'(bus.x_out) != p.x || int'(bus.y_out) != p.y || int'(bus.colour) != p.c) begin
                    failures++;
                    $display("FAIL pixel actual=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)",
                             bus.x_out, bus.y_out, bus.colour, p.x, p.y, p.c);
                end
            end
        end
    end

    task automatic tick(input bit l, input bit r);
        bus.enable = 1'b1; bus.left = l; bus.right = r;
        @(negedge clk);
        bus.enable = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        @(negedge clk);
    endtask

    // poke 1: extra draw_req mid-redraw; poke 2: move ticks with the request and mid-redraw
    task automatic redraw(input string name, input bit erase, input int ox, input int nx, input int poke);
        int cnt, done_at, d0, exp_busy;
        if (erase) push_scan(ox, 0);
        push_scan(nx, 4);
        exp_busy = erase ? 2 * N + 1 : N + 1;
        d0 = done_total;
        bus.draw_req = 1'b1;
        if (poke == 2) begin bus.enable = 1'b1; bus.right = 1'b1; end
        @(negedge clk);
        bus.draw_req = 1'b0; bus.enable = 1'b0; bus.right = 1'b0;
        cnt = 0; done_at = 0;
        while (bus.busy && cnt < 300) begin
            cnt++;
            if (bus.done) done_at = cnt;
            bus.draw_req = (poke == 1 && cnt == 5);
            bus.enable   = (poke == 2 && cnt == 3);
            bus.right    = (poke == 2 && cnt == 3);
            @(negedge clk);
        end
        bus.draw_req = 1'b0; bus.enable = 1'b0; bus.right = 1'b0;
        chk({name, "_busy_cycles"}, cnt, exp_busy);
        chk({name, "_done_cycle"}, done_at, exp_busy);
        chk({name, "_pixels_left"}, sbq.size(), 0);
        @(negedge clk);
        chk({name, "_idle_after"}, int'(bus.busy), 0);
        chk({name, "_done_pulses"}, done_total - d0, 1);
    endtask

    initial begin
        mv[0] = '{l: 1'b1, r: 1'b0, n: 75,  exp_pos: 0};
        mv[1] = '{l: 1'b1, r: 1'b0, n: 5,   exp_pos: 0};
        mv[2] = '{l: 1'b0, r: 1'b1, n: 5,   exp_pos: 5};
        mv[3] = '{l: 1'b1, r: 1'b1, n: 3,   exp_pos: 5};
        mv[4] = '{l: 1'b0, r: 1'b0, n: 2,   exp_pos: 5};
        mv[5] = '{l: 1'b0, r: 1'b1, n: 150, exp_pos: 144};
        mv[6] = '{l: 1'b1, r: 1'b0, n: 1,   exp_pos: 143};

        resetn = 1'b0;
        bus.enable = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.draw_req = 1'b0;
        bus2.enable = 1'b0; bus2.left = 1'b0; bus2.right = 1'b0; bus2.draw_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos_x", int'(bus.pos_x), 72);
        chk("rst_wren", int'(bus.wren), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_x_out", int'(bus.x_out), 0);
        chk("rst_y_out", int'(bus.y_out), 0);
        chk("rst_colour", int'(bus.colour), 0);
        chk("rst_pos_x_speed4", int'(bus2.pos_x), 72);
        resetn = 1'b1;
        @(negedge clk);

        redraw("first_draw", 1'b0, 0, 72, 0);

        repeat (3) tick(1'b0, 1'b1);
        chk("move_right3", int'(bus.pos_x), 75);
        redraw("erase_draw", 1'b1, 72, 75, 0);

        redraw("no_move_redraw", 1'b0, 0, 75, 1);

        redraw("tick_during_busy", 1'b0, 0, 75, 2);
        chk("pos_after_dropped_ticks", int'(bus.pos_x), 75);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < mv[i].n; k++) tick(mv[i].l, mv[i].r);
            chk($sformatf("move_vec%0d", i), int'(bus.pos_x), mv[i].exp_pos);
        end

        for (int k = 0; k < 17; k++) begin
            bus2.enable = 1'b1; bus2.right = 1'b1;
            @(negedge clk);
            bus2.enable = 1'b0; bus2.right = 1'b0;
            @(negedge clk);
            if (k == 16) chk("speed4_at_140", int'(bus2.pos_x), 140);
            if (k == 0)  chk("speed4_first", int'(bus2.pos_x), 76);
        end
        for (int k = 0; k < 2; k++) begin
            bus2.enable = 1'b1; bus2.right = 1'b1;
            @(negedge clk);
            bus2.enable = 1'b0; bus2.right = 1'b0;
            @(negedge clk);
            chk($sformatf("speed4_clamp%0d", k), int'(bus2.pos_x), 144);
        end
        for (int k = 0; k < 40; k++) begin
            bus2.enable = 1'b1; bus2.left = 1'b1;
            @(negedge clk);
            bus2.enable = 1'b0; bus2.left = 1'b0;
            @(negedge clk);
        end
        chk("speed4_left_sat", int'(bus2.pos_x), 0);

        push_scan(75, 0);
        for (int i = 0; i < 10; i++) sbq.push_back('{x: 143 + i, y: 110, c: 4});
        bus.draw_req = 1'b1;
        @(negedge clk);
        bus.draw_req = 1'b0;
        for (int i = 1; i < N + 10; i++) @(negedge clk);
        chk("reset_point_wren", int'(bus.wren), 1);
        chk("reset_point_x", int'(bus.x_out), 152);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_reset_wren", int'(bus.wren), 0);
        chk("mid_reset_busy", int'(bus.busy), 0);
        chk("mid_reset_pos", int'(bus.pos_x), 72);
        chk("mid_reset_pixels_left", sbq.size(), 0);
        resetn = 1'b1;
        @(negedge clk);
        redraw("post_reset", 1'b0, 0, 72, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
